// File: rtl/ahb_mtx_input_stage.sv
// AHB bus-matrix input stage: forwards the live address phase to the decoder, or
// parks it in a holding register and stalls the master until the output stage grants it.
module ahb_mtx_input_stage (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic        sel_in,
  output logic [31:0] addr_in,
  output logic [1:0]  trans_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [2:0]  burst_in,
  output logic [3:0]  prot_in,
  output logic        mastlock_in,
  output logic        ready_in,
  output logic        held_tran,
  input  logic        active_in,
  input  logic        readyout_in,
  input  logic [1:0]  resp_in
);

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_HELD = 1'b1
  } pend_t;

  pend_t       pend_q, pend_d;
  logic        new_tran;
  logic        hold_load;

  logic [31:0] reg_addr;
  logic [1:0]  reg_trans;
  logic        reg_write;
  logic [2:0]  reg_size;
  logic [2:0]  reg_burst;
  logic [3:0]  reg_prot;
  logic        reg_mastlock;

  assign new_tran  = HSELS & HTRANSS[1] & HREADYS;
  // Loading is suppressed while held so an illegal new_tran cannot corrupt the parked phase.
  assign hold_load = HREADYS & (pend_q == PEND_IDLE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q       <= PEND_IDLE;
      reg_addr     <= '0;
      reg_trans    <= '0;
      reg_write    <= 1'b0;
      reg_size     <= '0;
      reg_burst    <= '0;
      reg_prot     <= '0;
      reg_mastlock <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (hold_load) begin
        reg_addr     <= HADDRS;
        reg_trans    <= HTRANSS;
        reg_write    <= HWRITES;
        reg_size     <= HSIZES;
        reg_burst    <= HBURSTS;
        reg_prot     <= HPROTS;
        reg_mastlock <= HMASTLOCKS;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    unique case (pend_q)
      PEND_IDLE: if (new_tran && !active_in)    pend_d = PEND_HELD;
      PEND_HELD: if (active_in && readyout_in)  pend_d = PEND_IDLE;
      default:                                  pend_d = PEND_IDLE;
    endcase
  end

  always_comb begin
    sel_in      = HSELS;
    addr_in     = HADDRS;
    trans_in    = HTRANSS;
    write_in    = HWRITES;
    size_in     = HSIZES;
    burst_in    = HBURSTS;
    prot_in     = HPROTS;
    mastlock_in = HMASTLOCKS;
    ready_in    = HREADYS;
    held_tran   = 1'b0;
    HREADYOUTS  = readyout_in;
    HRESPS      = resp_in;
    if (pend_q == PEND_HELD) begin
      sel_in      = 1'b1;
      addr_in     = reg_addr;
      // Output stage may have re-arbitrated, so a parked SEQ is re-issued as NONSEQ.
      trans_in    = reg_trans[1] ? 2'b10 : reg_trans;
      write_in    = reg_write;
      size_in     = reg_size;
      burst_in    = reg_burst;
      prot_in     = reg_prot;
      mastlock_in = reg_mastlock;
      ready_in    = readyout_in;
      held_tran   = 1'b1;
      HREADYOUTS  = 1'b0;
      HRESPS      = 2'b00;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed-vector bench for ahb_mtx_input_stage; expected outputs per cycle are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_ahb_mtx_input_stage;

  logic        HCLK, HRESET, HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_in, write_in, mastlock_in, ready_in, held_tran;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic [2:0]  size_in, burst_in;
  logic [3:0]  prot_in;
  logic        active_in, readyout_in;
  logic [1:0]  resp_in;

  ahb_mtx_input_stage dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_in(sel_in), .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
    .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in), .mastlock_in(mastlock_in),
    .ready_in(ready_in), .held_tran(held_tran), .active_in(active_in),
    .readyout_in(readyout_in), .resp_in(resp_in)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rdyout;
    logic [1:0]  resp;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        ready;
    logic        held;
    logic        wr;
    logic [10:0] ctl;
  } exp_t;

  // ctl = {size, burst, prot, mastlock}
  localparam logic [10:0] C0 = 11'd0;
  localparam logic [10:0] C1 = {3'd2, 3'd1, 4'h3, 1'b0};
  localparam logic [10:0] C2 = {3'd1, 3'd3, 4'hA, 1'b1};
  localparam logic [10:0] C3 = {3'd0, 3'd7, 4'h5, 1'b1};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  task automatic chk(input string nm, input int v, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL vec%0d %s actual=%h required=%h", v, nm, a, e);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    int   v;
    v = 0;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        v++;
        chk("HREADYOUTS", v, {31'd0, HREADYOUTS}, {31'd0, e.rdyout});
        chk("HRESPS",     v, {30'd0, HRESPS},     {30'd0, e.resp});
        chk("sel_in",     v, {31'd0, sel_in},     {31'd0, e.sel});
        chk("addr_in",    v, addr_in,             e.addr);
        chk("trans_in",   v, {30'd0, trans_in},   {30'd0, e.trans});
        chk("ready_in",   v, {31'd0, ready_in},   {31'd0, e.ready});
        chk("held_tran",  v, {31'd0, held_tran},  {31'd0, e.held});
        chk("write_in",   v, {31'd0, write_in},   {31'd0, e.wr});
        chk("ctl_in",     v, {21'd0, size_in, burst_in, prot_in, mastlock_in}, {21'd0, e.ctl});
      end
    end
  end

  task automatic vec(input logic rst, input logic sel, input logic [1:0] tr,
                     input logic [31:0] ad, input logic wr, input logic [10:0] ctl,
                     input logic hr, input logic act, input logic rdy,
                     input logic [1:0] rsp, input exp_t e);
    @(posedge HCLK);
    #1;
    HRESET = rst; HSELS = sel; HTRANSS = tr; HADDRS = ad; HWRITES = wr;
    {HSIZES, HBURSTS, HPROTS, HMASTLOCKS} = ctl;
    HREADYS = hr; active_in = act; readyout_in = rdy; resp_in = rsp;
    q.push_back(e);
    vec_no++;
  endtask

  initial begin
    HRESET = 1'b1; HSELS = 1'b0; HTRANSS = 2'b00; HADDRS = '0; HWRITES = 1'b0;
    HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
    active_in = 1'b0; readyout_in = 1'b1; resp_in = 2'b00;

    //   rst  sel tr     addr          wr  ctl hr  act rdy rsp      rdyout rsp  sel addr         tr    rdy held wr ctl
    // reset: pend=0 mux, outputs pass through
    vec(1, 1, 2'b00, 32'hAAAA_0000, 0, C0, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 1, 32'hAAAA_0000, 2'b00, 1, 0, 0, C0});
    vec(1, 0, 2'b00, 32'hAAAA_0004, 0, C0, 1, 0, 0, 2'b10, exp_t'{0, 2'b10, 0, 32'hAAAA_0004, 2'b00, 1, 0, 0, C0});
    // granted NONSEQ read to 0x400
    vec(0, 1, 2'b10, 32'h0000_0400, 0, C1, 1, 1, 1, 2'b00, exp_t'{1, 2'b00, 1, 32'h0000_0400, 2'b10, 1, 0, 0, C1});
    vec(0, 0, 2'b00, 32'h0000_0000, 0, C0, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 0, 32'h0000_0000, 2'b00, 1, 0, 0, C0});
    // stalled NONSEQ write to 0x1000: capture, 3 held cycles, grant on the 3rd
    vec(0, 1, 2'b10, 32'h0000_1000, 1, C2, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 1, 32'h0000_1000, 2'b10, 1, 0, 1, C2});
    vec(0, 1, 2'b11, 32'h0000_2222, 0, C3, 0, 0, 1, 2'b01, exp_t'{0, 2'b00, 1, 32'h0000_1000, 2'b10, 1, 1, 1, C2});
    vec(0, 1, 2'b11, 32'h0000_2222, 0, C3, 0, 0, 0, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_1000, 2'b10, 0, 1, 1, C2});
    vec(0, 1, 2'b11, 32'h0000_2222, 0, C3, 0, 1, 1, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_1000, 2'b10, 1, 1, 1, C2});
    vec(0, 0, 2'b00, 32'h0000_3000, 0, C0, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 0, 32'h0000_3000, 2'b00, 1, 0, 0, C0});
    // live SEQ passes as 11, then is captured and re-issued as NONSEQ
    vec(0, 1, 2'b11, 32'h0000_2004, 0, C1, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 1, 32'h0000_2004, 2'b11, 1, 0, 0, C1});
    vec(0, 0, 2'b01, 32'h0000_5555, 1, C3, 0, 0, 0, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_2004, 2'b10, 0, 1, 0, C1});
    // illegal new_tran while held must be ignored
    vec(0, 1, 2'b10, 32'h0000_7770, 1, C2, 1, 0, 0, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_2004, 2'b10, 0, 1, 0, C1});
    // reset while held: still held this cycle, dropped at the edge
    vec(1, 0, 2'b00, 32'h0000_8000, 0, C0, 0, 0, 1, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_2004, 2'b10, 1, 1, 0, C1});
    vec(0, 1, 2'b00, 32'h0000_9000, 0, C0, 1, 0, 0, 2'b00, exp_t'{0, 2'b00, 1, 32'h0000_9000, 2'b00, 1, 0, 0, C0});
    // IDLE/BUSY with HSELS=1 and no grant never set pend
    vec(0, 1, 2'b01, 32'h0000_9004, 0, C0, 1, 0, 1, 2'b00, exp_t'{1, 2'b00, 1, 32'h0000_9004, 2'b01, 1, 0, 0, C0});
    // two-cycle ERROR passes through while not held
    vec(0, 0, 2'b00, 32'h0000_0000, 0, C0, 0, 0, 0, 2'b01, exp_t'{0, 2'b01, 0, 32'h0000_0000, 2'b00, 0, 0, 0, C0});
    vec(0, 0, 2'b00, 32'h0000_0000, 0, C0, 0, 0, 1, 2'b01, exp_t'{1, 2'b01, 0, 32'h0000_0000, 2'b00, 0, 0, 0, C0});

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge HCLK);
    @(posedge HCLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count actual=%0d required>=12", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
